sarlock_key_loader: RTL and testbench

Sequential key-provisioning controller for the SARLock-protected datapath. Accepts the secret key in CHUNK_W-bit beats over a valid/ready stream, assembles it in a shift register and checks beat count and framing (and optionally parity). Presents the key to the locked circuit's key bus only once the load completes cleanly; at all other times the bus carries all-zero. Sits between the on-chip key store / tamper-proof memory interface and the key input of the locked module.

---
 rtl/kin_if.sv | 34 +++
 rtl/sarlock_key_loader.sv | 156 +++++++++++++++
 tb/tb_sarlock_key_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/kin_if.sv
//------------------------------------------------------------------------------
// kin_if
// Valid/ready key-beat stream carrying one CHUNK_W chunk plus framing/parity.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface kin_if #(
    parameter int CHUNK_W = 1
);
    logic               valid;
    logic               ready;
    logic [CHUNK_W-1:0] data;
    logic               last;
    logic               par;

    modport master (
        output valid,
        output data,
        output last,
        output par,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        input  par,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/sarlock_key_loader.sv
//------------------------------------------------------------------------------
// sarlock_key_loader
// Assembles a SARLock key from a beat stream and exposes it only after a clean
// load. Optional parity check enabled by defining KEYLOAD_PARITY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sarlock_key_loader #(
    parameter int KEY_W   = 8,
    parameter int CHUNK_W = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             clear,
    kin_if.slave                  kin,
    output logic [KEY_W-1:0]      key,
    output logic                  key_valid,
    output logic                  busy,
    output logic                  error
);

    localparam int c_N_BEATS = KEY_W / CHUNK_W;
    localparam int c_CNT_W   = $clog2(c_N_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_N_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [KEY_W-1:0]     r_sr;
    logic [KEY_W-1:0]     w_sr_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]     r_key;
    logic                 w_xfer;
    logic                 w_check;
    logic                 w_sr_clr;
    logic                 w_shift;
    logic                 w_arm;

    assign kin.ready = (r_state == ST_LOAD);
    assign w_xfer    = kin.valid && kin.ready;

    generate
        if (KEY_W == CHUNK_W) begin : g_single
            assign w_sr_next = kin.data;
        end else begin : g_shift
            assign w_sr_next = {r_sr[KEY_W-CHUNK_W-1:0], kin.data};
        end
    endgenerate

`ifdef KEYLOAD_PARITY_EN
    // Even parity over the whole assembled key plus the sideband bit.
    assign w_check = ~((^w_sr_next) ^ kin.par);
`else
    logic w_unused_par;
    assign w_unused_par = kin.par;
    assign w_check      = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_sr_clr     = 1'b0;
        w_shift      = 1'b0;
        w_arm        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                    w_sr_clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    w_shift = 1'b1;
                    // The final beat always leaves LOAD, so the counter never wraps.
                    if (r_cnt == c_LAST_CNT) begin
                        if (kin.last && w_check) begin
                            w_state_next = ST_ARMED;
                            w_arm        = 1'b1;
                        end else begin
                            w_state_next = ST_FAULT;
                        end
                    end else if (kin.last) begin
                        w_state_next = ST_FAULT;
                    end
                end
            end
            ST_ARMED: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                    w_sr_clr     = 1'b1;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // clear outranks start and drops any beat offered in the same cycle.
        if (clear) begin
            w_state_next = ST_IDLE;
            w_sr_clr     = 1'b1;
            w_shift      = 1'b0;
            w_arm        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_sr_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Key register is forced to zero whenever the next state is not ARMED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (w_arm) begin
            r_key <= w_sr_next;
        end else if (w_state_next != ST_ARMED) begin
            r_key <= '0;
        end
    end

    assign key       = r_key;
    assign key_valid = (r_state == ST_ARMED);
    assign busy      = (r_state == ST_LOAD);
    assign error     = (r_state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_sarlock_key_loader.sv
//------------------------------------------------------------------------------
// tb_sarlock_key_loader
// Directed and randomized checks of sarlock_key_loader against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sarlock_key_loader;

    localparam int KEY_W   = 8;
    localparam int CHUNK_W = 1;
    localparam int N       = KEY_W / CHUNK_W;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_ARMED = 2;
    localparam int M_FAULT = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             busy;
    logic             error;

    kin_if #(.CHUNK_W(CHUNK_W)) kin ();

    sarlock_key_loader #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .kin       (kin),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int                 m_mode = M_IDLE;
    logic [KEY_W-1:0]   m_key  = '0;
    logic [CHUNK_W-1:0] beats[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [KEY_W-1:0] assemble();
        logic [KEY_W-1:0] k = '0;
        foreach (beats[i]) k = (k << CHUNK_W) | KEY_W'(beats[i]);
        return k;
    endfunction

    function automatic bit par_ok(input logic [KEY_W-1:0] k, input logic p);
`ifdef KEYLOAD_PARITY_EN
        return ((^k) ^ p) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_key  = '0;
        beats.delete();
    endfunction

    task automatic check_outputs();
        check("key",       64'(key),       64'(m_key));
        check("key_valid", 64'(key_valid), 64'(m_mode == M_ARMED));
        check("busy",      64'(busy),      64'(m_mode == M_LOAD));
        check("error",     64'(error),     64'(m_mode == M_FAULT));
        check("kin_ready", 64'(kin.ready), 64'(m_mode == M_LOAD));
    endtask

    // Called just after a falling edge: check, apply inputs, advance model, wait one cycle.
    task automatic drive_cycle(input logic s, input logic c, input logic v,
                               input logic [CHUNK_W-1:0] d, input logic l, input logic p);
        logic [KEY_W-1:0] k;
        check_outputs();
        start     = s;
        clear     = c;
        kin.valid = v;
        kin.data  = d;
        kin.last  = l;
        kin.par   = p;
        if (c) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin m_mode = M_LOAD; beats.delete(); end
                M_LOAD: if (v) begin
                    beats.push_back(d);
                    if (l || beats.size() == N) begin
                        k = assemble();
                        if (l && beats.size() == N && par_ok(k, p)) begin
                            m_mode = M_ARMED;
                            m_key  = k;
                        end else begin
                            m_mode = M_FAULT;
                            m_key  = '0;
                        end
                    end
                end
                M_ARMED: if (s) begin m_mode = M_LOAD; m_key = '0; beats.delete(); end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [KEY_W-1:0] val, input int i, input logic l, input logic p);
        logic [KEY_W-1:0] sh;
        sh = val >> (KEY_W - (i + 1) * CHUNK_W);
        drive_cycle(1'b0, 1'b0, 1'b1, sh[CHUNK_W-1:0], l, p);
    endtask

    task automatic load_key(input logic [KEY_W-1:0] val, input logic p);
        for (int i = 0; i < N; i++) beat(val, i, (i == N - 1), p);
    endtask

    initial begin
        logic             s, c, v, l, p, correct;
        logic [CHUNK_W-1:0] d;
        logic [KEY_W-1:0]   pk;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        kin.valid = 1'b0; kin.data = '0; kin.last = 1'b0; kin.par = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_key", 64'(key), 64'h0);
        check_outputs();
        rst_n = 1'b1;
        idle_cycle();

        // Clean load of 8'h6D
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        load_key(8'h6D, 1'b1);
        check("key_6D", 64'(key), 64'h6D);
        check("kv_6D", 64'(key_valid), 64'h1);
        idle_cycle();

        // Reload invalidates the old key immediately
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("key_zero_on_reload", 64'(key), 64'h0);
        load_key(8'hA5, 1'b0);
        check("key_A5", 64'(key), 64'hA5);
        drive_cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Bad parity (faults only in the parity build)
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        load_key(8'h6D, 1'b0);
        idle_cycle();
        drive_cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle_cycle();

        // Short key: last on beat 5, then a start in FAULT is ignored
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) beat(8'h6D, i, (i == 4), 1'b0);
        check("short_err", 64'(error), 64'h1);
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_cycle();
        drive_cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Missing last on beat N
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) beat(8'h3C, i, 1'b0, 1'b0);
        check("nolast_err", 64'(error), 64'h1);
        drive_cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-load
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat(8'hFF, i, 1'b0, 1'b0);
        kin.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_key", 64'(key), 64'h0);
        check("arst_kv", 64'(key_valid), 64'h0);
        check("arst_ready", 64'(kin.ready), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        load_key(8'hFF, 1'b0);
        check("key_FF", 64'(key), 64'hFF);

        // clear together with a beat drops it
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h96, i, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_busy", 64'(busy), 64'h0);

        // Stall mid-load; counter holds
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h96, i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle();
        for (int i = 3; i < N; i++) beat(8'h96, i, (i == N - 1), 1'b0);
        check("key_96", 64'(key), 64'h96);

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            s = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = CHUNK_W'($urandom);
            correct = (beats.size() + 1 == N);
            l = ($urandom_range(0, 15) == 0) ? !correct : correct;
            pk = (assemble() << CHUNK_W) | KEY_W'(d);
            p = (^pk) ^ ($urandom_range(0, 7) == 0);
            drive_cycle(s, c, v, d, l, p);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
